// File: rtl/io_bus_pkg.sv
// Shared definitions for the MMIO window: sequencer state encoding,
// window geometry and the fixed peripheral index map.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } io_state_e;

  localparam logic [21:0] IO_BASE_HIGH  = 22'h3FFFFF;
  localparam int          DEV_WIN_BYTES = 16;
  localparam int          OFS_W         = $clog2(DEV_WIN_BYTES);
  localparam logic [31:0] ERR_RDATA     = 32'h0000_0000;

  localparam int DEV_SWITCH = 0;
  localparam int DEV_LED    = 1;
  localparam int DEV_SEG    = 2;
  localparam int DEV_KEY    = 3;

endpackage

// File: rtl/mmio_addr_decode.sv
// Splits the low address into a device window index and an in-window offset,
// and flags indices beyond the populated peripherals as unmapped.
module mmio_addr_decode
  import io_bus_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int ADDR_W  = 10
) (
  input  logic [ADDR_W-1:0]       addr_low,
  output logic [ADDR_W-OFS_W-1:0] idx,
  output logic [OFS_W-1:0]        offset,
  output logic [NUM_DEV-1:0]      onehot,
  output logic                    mapped
);

  localparam int IDX_W = ADDR_W - OFS_W;

  assign idx    = addr_low[ADDR_W-1:OFS_W];
  assign offset = addr_low[OFS_W-1:0];
  assign mapped = (idx < IDX_W'(NUM_DEV));

  // An unmapped index naturally yields an all-zero select.
  for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_onehot
    assign onehot[gi] = (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/mmio_access_sequencer.sv
// Stalls the single-cycle core while one MMIO access runs a req/ack handshake
// with the addressed peripheral, returning load data or a bus error.
module mmio_access_sequencer
  import io_bus_pkg::*;
#(
  parameter int NUM_DEV     = 4,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [ADDR_W-1:0]     addr_low,
  input  logic [31:0]           wdata,
  output logic                  cpu_stall,
  output logic [31:0]           rdata,
  output logic                  rdata_valid,
  output logic                  bus_error,
  output logic [NUM_DEV-1:0]    dev_sel,
  output logic                  dev_req,
  output logic                  dev_we,
  output logic [3:0]            dev_addr,
  output logic [31:0]           dev_wdata,
  input  logic [NUM_DEV-1:0]    dev_ack,
  input  logic [NUM_DEV*32-1:0] dev_rdata
);

  localparam int IDX_W = ADDR_W - OFS_W;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  io_state_e          state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DEV-1:0] sel_q, sel_d;
  logic [OFS_W-1:0]   ofs_q, ofs_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   dec_idx;
  logic [OFS_W-1:0]   dec_ofs;
  logic [NUM_DEV-1:0] dec_onehot;
  logic               dec_mapped;
  logic               strobe;
  logic               ack_hit;
  logic [31:0]        rd_slice;

  mmio_addr_decode #(
    .NUM_DEV (NUM_DEV),
    .ADDR_W  (ADDR_W)
  ) u_decode (
    .addr_low (addr_low),
    .idx      (dec_idx),
    .offset   (dec_ofs),
    .onehot   (dec_onehot),
    .mapped   (dec_mapped)
  );

  assign strobe  = io_read | io_write;
  // Acks from peripherals other than the one being addressed are ignored.
  assign ack_hit = |(dev_ack & sel_q);

  always_comb begin
    rd_slice = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (idx_q == IDX_W'(i)) rd_slice = dev_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sel_q   <= '0;
      ofs_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      ofs_q   <= ofs_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    ofs_d   = ofs_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (strobe) begin
          idx_d   = dec_idx;
          sel_d   = dec_onehot;
          ofs_d   = dec_ofs;
          wdata_d = wdata;
          we_d    = io_write;
          cnt_d   = '0;
          state_d = dec_mapped ? ST_WAIT : ST_ERR;
        end
      end
      ST_WAIT: begin
        // Ack takes priority over an expiring count in the same cycle.
        if (ack_hit) begin
          rdata_d = we_q ? 32'h0 : rd_slice;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The strobe still high here belongs to the retiring instruction.
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall   = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
    bus_error   = 1'b0;
    dev_sel     = '0;
    dev_req     = 1'b0;
    dev_we      = 1'b0;
    dev_addr    = '0;
    dev_wdata   = '0;
    unique case (state_q)
      ST_IDLE: cpu_stall = strobe & rst_n;
      ST_WAIT: begin
        cpu_stall = 1'b1;
        dev_req   = 1'b1;
        dev_sel   = sel_q;
        dev_we    = we_q;
        dev_addr  = 4'(ofs_q);
        dev_wdata = wdata_q;
      end
      ST_DONE: begin
        rdata       = rdata_q;
        rdata_valid = ~we_q;
      end
      ST_ERR: begin
        rdata       = ERR_RDATA;
        rdata_valid = ~we_q;
        bus_error   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
